// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: small byte FIFO fed by word-addressed I/O strobes,
// fixed-rate serialiser on txd, STATUS/DATA read port.
`timescale 1ns / 1ps
module uart_tx_mmio #(
  parameter int unsigned CLK_FREQ_HZ = 12_000_000,
  parameter int unsigned BAUD        = 115_200,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        io_wr,
  input  logic        io_rd,
  input  logic        io_addr,
  input  logic [31:0] io_wdata,
  output logic [31:0] io_rdata,
  output logic        txd
);

  localparam int unsigned DIV    = CLK_FREQ_HZ / BAUD;
  localparam int unsigned BAUD_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int unsigned PTR_W  = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W  = 5;

  if (DIV < 2) begin : g_div_check
    $error("uart_tx_mmio: CLK_FREQ_HZ / BAUD must be at least 2");
  end
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)
  begin : g_depth_check
    $error("uart_tx_mmio: FIFO_DEPTH must be a power of two in 2..16");
  end

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  // FIFO
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             overflow_q;
  logic             full, empty, data_wr, push, pop;

  assign full    = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign data_wr = io_wr && !io_addr;
  assign push    = data_wr && !full;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= io_wdata[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_q <= count_q + CNT_W'(1);
      else if (pop && !push) count_q <= count_q - CNT_W'(1);
      // A dropped write and a clear cannot coincide: there is only one write strobe.
      if (data_wr && full)                       overflow_q <= 1'b1;
      else if (io_wr && io_addr && io_wdata[3])  overflow_q <= 1'b0;
    end
  end

  // Transmit FSM
  state_e            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              txd_q, txd_d;
  logic              baud_last;

  assign baud_last = (baud_q == BAUD_W'(DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        txd_d = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          txd_d   = 1'b0;
          baud_d  = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          txd_d   = shift_q[0];
          state_d = StData;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      StData: begin
        if (baud_last) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            txd_d   = 1'b1;
            state_d = StStop;
          end else begin
            txd_d = shift_q[1];
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      StStop: begin
        if (baud_last) begin
          baud_d = '0;
          // Back-to-back frames: go straight to the next start bit.
          if (!empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            txd_d   = 1'b0;
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Read port
  logic [31:0] status;
  logic [31:0] rdata_q;
  logic        unused_wdata;

  assign status = {23'b0, count_q, overflow_q, empty, full, state_q != StIdle};
  assign unused_wdata = ^{io_wdata[31:8]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rdata_q <= '0;
    else if (io_rd) rdata_q <= io_addr ? status : 32'h0;
  end

  assign io_rdata = rdata_q;
  assign txd      = txd_q;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio at DIV=10, FIFO_DEPTH=4; frames checked at mid-bit.
`timescale 1ns / 1ps
module tb_uart_tx_mmio;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        io_wr = 1'b0;
  logic        io_rd = 1'b0;
  logic        io_addr = 1'b0;
  logic [31:0] io_wdata = '0;
  logic [31:0] io_rdata;
  logic        txd;

  int unsigned cyc = 0;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  uart_tx_mmio #(
    .CLK_FREQ_HZ(1_000_000),
    .BAUD       (100_000),
    .FIFO_DEPTH (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .io_wr   (io_wr),
    .io_rd   (io_rd),
    .io_addr (io_addr),
    .io_wdata(io_wdata),
    .io_rdata(io_rdata),
    .txd     (txd)
  );

  always #5 clk = ~clk;
  // cyc holds the number of the most recent rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int unsigned t);
    while (cyc < t) @(negedge clk);
  endtask

  // Called at a negedge; the access happens on the following rising edge.
  task automatic io_cycle(input logic wr, input logic rd, input logic addr,
                          input logic [31:0] wdata, output logic [31:0] rdata);
    io_wr = wr;
    io_rd = rd;
    io_addr = addr;
    io_wdata = wdata;
    @(negedge clk);
    io_wr = 1'b0;
    io_rd = 1'b0;
    rdata = io_rdata;
  endtask

  task automatic io_write(input logic addr, input logic [31:0] wdata);
    logic [31:0] dummy;
    io_cycle(1'b1, 1'b0, addr, wdata, dummy);
  endtask

  task automatic io_read(input logic addr, output logic [31:0] rdata);
    io_cycle(1'b0, 1'b1, addr, 32'h0, rdata);
  endtask

  // Frame whose start bit begins right after edge s; bit k sampled after edge s+10k+5.
  task automatic check_frame(input string tag, input int unsigned s, input logic [7:0] exp);
    logic [9:0] bits;
    for (int k = 0; k < 10; k++) begin
      wait_cyc(s + 10 * k + 5);
      bits[k] = txd;
    end
    check({tag, "/start"}, {31'b0, bits[0]}, 32'h0);
    check({tag, "/data"}, {24'b0, bits[8:1]}, {24'b0, exp});
    check({tag, "/stop"}, {31'b0, bits[9]}, 32'h1);
  endtask

  task automatic check_high(input string tag, input int unsigned from, input int unsigned len);
    logic all_high = 1'b1;
    for (int unsigned c = from; c < from + len; c++) begin
      wait_cyc(c);
      if (txd !== 1'b1) all_high = 1'b0;
    end
    check(tag, {31'b0, all_high}, 32'h1);
  endtask

  initial begin
    logic [31:0] rd;
    int unsigned n;
    int unsigned n0;

    // 1: reset state
    repeat (3) @(negedge clk);
    check("rst/rdata", io_rdata, 32'h0);
    check("rst/txd", {31'b0, txd}, 32'h1);
    rst = 1'b0;
    io_read(1'b1, rd);
    check("rst/status", rd, 32'h4);
    check_high("rst/idle_high", cyc, 50);

    // 2: single frame, upper write bits ignored
    io_write(1'b0, 32'h1A5);
    n = cyc;
    check("f1/txd_at_n", {31'b0, txd}, 32'h1);
    wait_cyc(n + 1);
    check("f1/txd_at_n1", {31'b0, txd}, 32'h0);
    io_read(1'b0, rd);
    check("f1/data_read", rd, 32'h0);
    check_frame("f1", n + 1, 8'hA5);
    check_high("f1/after", n + 101, 30);

    // 3: back-to-back frames, busy boundary
    io_write(1'b0, 32'h55);
    n = cyc;
    io_write(1'b0, 32'h0F);
    check_frame("b2b0", n + 1, 8'h55);
    check_frame("b2b1", n + 101, 8'h0F);
    wait_cyc(n + 200);
    io_read(1'b1, rd);
    check("b2b/status_stop", rd, 32'h5);
    io_read(1'b1, rd);
    check("b2b/status_idle", rd, 32'h4);

    // 4: overflow with six consecutive writes into a depth-4 FIFO
    for (int k = 0; k < 6; k++) io_write(1'b0, 32'h11 + k);
    n = cyc - 5;
    io_read(1'b1, rd);
    check("ovf/status", rd, 32'h4B);
    io_cycle(1'b1, 1'b1, 1'b1, 32'h8, rd);
    check("ovf/rd_with_clear", rd, 32'h4B);
    io_read(1'b1, rd);
    check("ovf/cleared", rd, 32'h43);
    check_frame("ovf0", n + 1, 8'h11);
    check_frame("ovf1", n + 101, 8'h12);
    check_frame("ovf4", n + 401, 8'h15);
    wait_cyc(n + 510);
    io_read(1'b1, rd);
    check("ovf/drained", rd, 32'h4);

    // 5: reset in mid-frame
    io_write(1'b0, 32'h3A);
    n = cyc;
    io_write(1'b0, 32'h77);
    wait_cyc(n + 1 + 35);
    check("rstmid/pre_txd", {31'b0, txd}, 32'h0);
    rst = 1'b1;
    #1;
    check("rstmid/txd", {31'b0, txd}, 32'h1);
    check("rstmid/rdata", io_rdata, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    io_read(1'b1, rd);
    check("rstmid/status", rd, 32'h4);
    check_high("rstmid/discarded", cyc, 30);
    io_write(1'b0, 32'hC3);
    n = cyc;
    check_frame("rstmid/fresh", n + 1, 8'hC3);

    // 6: twelve bytes through the FIFO, pointers wrap, no gaps
    wait_cyc(n + 120);
    n0 = cyc + 1;
    fork
      begin
        for (int k = 0; k < 4; k++) io_write(1'b0, k);
        for (int k = 4; k < 12; k++) begin
          wait_cyc(n0 + 3 + 100 * (k - 3) - 1);
          io_write(1'b0, k);
        end
      end
      begin
        for (int j = 0; j < 12; j++) check_frame("wrap", n0 + 1 + 100 * j, 8'(j));
      end
    join
    wait_cyc(n0 + 1 + 1200 + 5);
    io_read(1'b1, rd);
    check("wrap/status_end", rd, 32'h4);
    check("wrap/txd_end", {31'b0, txd}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_mmio.md
# uart_tx_mmio

Memory-mapped UART transmitter for the RV32I SoC. It sits downstream of the core's store path and drives the `txd` pin. The core writes bytes into a small FIFO through a word-addressed I/O strobe interface. The block serialises each byte as 8N1 at a fixed baud rate and reports status back through a read port.

## Interface

Parameters:
- `CLK_FREQ_HZ`, default 12_000_000: system clock frequency.
- `BAUD`, default 115_200: line rate.
- `FIFO_DEPTH`, default 4: transmit FIFO entries; power of two, 2..16.

Derived value:
- DIV = CLK_FREQ_HZ / BAUD, using integer division.
- DIV must be at least 2; elaboration fails otherwise.

Ports:
- `clk`  in  1: system clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `io_wr`  in  1: write strobe, one cycle per access.
- `io_rd`  in  1: read strobe, one cycle per access.
- `io_addr`  in  1: register select; 0 = DATA, 1 = STATUS.
- `io_wdata`  in  32: write data.
- `io_rdata`  out  32: registered read data.
- `txd`  out  1: serial output; idle level is high.

## Operation

Registers:
- DATA write: enqueues `io_wdata[7:0]`. Upper bits are ignored.
- DATA read: returns 0.
- STATUS read bits:
  - [0] busy: FSM is not IDLE.
  - [1] full.
  - [2] empty.
  - [3] overflow, sticky.
  - [8:4] FIFO count.
  - All other bits 0.
- STATUS write: if `io_wdata[3]` is 1, clears overflow. Other bits are ignored.

FIFO:
- Circular buffer with read/write pointers and a count of 0..FIFO_DEPTH.
- Full and empty are evaluated on the pre-edge count.
- A DATA write while full is dropped, the FIFO is unchanged, and overflow is set. This holds even if the FSM pops in the same cycle.
- A write and a pop in the same cycle with count between 1 and DEPTH-1: both take effect and the count is unchanged.
- A write and a pop are never possible together when count is 0, because the pop requires not-empty.
- Pointers wrap modulo FIFO_DEPTH.

Transmit FSM states: IDLE, START, DATA, STOP. A baud counter counts 0..DIV-1 and a bit index counts 0..7.
- IDLE: `txd`=1. If not empty, pop the head into the shift register, set `txd`<=0, clear the baud counter, and go to START.
- START: hold for DIV cycles, then `txd`<=shift[0] and go to DATA with bit index 0.
- DATA: each bit is held DIV cycles, sent LSB first. After each bit, shift right and increment the bit index. After bit 7, `txd`<=1 and go to STOP.
- STOP: hold high for DIV cycles. At the end:
  - If not empty, pop directly into START with no idle gap (back-to-back frames).
  - Otherwise go to IDLE.

Read path:
- `io_rdata` is updated on the edge where `io_rd`=1.
- It holds its value otherwise.
- It samples state from before that edge.

## Timing

- Reset values:
  - `txd`=1.
  - `io_rdata`=0.
  - FSM in IDLE.
  - FIFO empty, pointers 0.
  - overflow=0.
  - Baud counter and shift register 0.
- Reset mid-frame aborts the frame. `txd` returns high asynchronously and queued bytes are discarded.
- Write latency: a write at edge N to an empty FIFO with the FSM in IDLE sees the FIFO non-empty after N. `txd` falls at edge N+1.
- Frame length is exactly 10*DIV cycles from the falling `txd` edge to the end of STOP.
- A STATUS read at edge N appears on `io_rdata` after edge N. Busy reads 0 only when in IDLE.
- Simultaneous `io_wr` and `io_rd` in one cycle are both serviced. The read reflects pre-write state.
- Overflow set by a write and cleared in the same cycle cannot occur, because there is a single write strobe.

## Test plan

Bench configuration: CLK_FREQ_HZ=1_000_000, BAUD=100_000, so DIV=10.

1. After reset, read STATUS: `io_rdata`=0x00000004 (empty), and `txd`=1 for 50 cycles.
2. Write DATA=0x1A5 at edge N: `txd` low at N+1. Sample the line at the middle of each bit: start=0, then bits 1,0,1,0,0,1,0,1 (0xA5 LSB first), stop=1. `txd` stays high from N+101 onward.
3. Write 0x55 then 0x0F on consecutive cycles: two frames back-to-back, with the second start bit beginning exactly 100 cycles after the first. STATUS busy=0 after 200 cycles plus 1.
4. Write 6 bytes in 6 consecutive cycles with DEPTH=4: first pops at cycle 2, so 5 bytes are accepted and the 6th is dropped. STATUS reads overflow=1 and count=4. Write STATUS bit3: overflow reads 0.
5. Assert `rst` 35 cycles into a frame: `txd`=1 immediately and STATUS=0x00000004. A fresh write afterwards transmits correctly.
6. FIFO wrap: stream 12 bytes 0x00..0x0B, keeping the FIFO non-full. The decoded byte sequence matches exactly with no gaps between frames.
